sta_output_requant: RTL and testbench

- Downstream neighbour of the 4x4 systolic tensor array.
- On `capture`, snapshots the array's 16 int32 accumulators (C0..C3). Then drains them row by row through a pipelined TFLite-style requantizer: multiply, rounding shift, zero-point add, clamp.
- Emits one 4-wide int8 output row per beat on a valid/ready stream to the output buffer/writeback.
- Frees the array for the next tile as soon as the snapshot is taken.

---
 rtl/sta_output_requant.sv | 206 ++++++++++++++++++++
 tb/tb_sta_output_requant.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/sta_output_requant.sv
// Output requantizer for the 4x4 systolic tensor array.
// Snapshots the int32 accumulator tile on capture, then drains the selected rows
// through a 3-stage requantizer (multiply, rounding shift, zero-point + clamp)
// and emits one int8 row per beat on a valid/ready stream.
module sta_output_requant #(
   parameter int N     = 4,
   parameter int ACC_W = 32,
   parameter int OUT_W = 8
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   capture,
   output logic                   capture_ready,
   input  logic [N*N*ACC_W-1:0]   c_in,
   input  logic [N-1:0]           row_mask,
   input  logic [31:0]            qmult,
   input  logic [4:0]             qshift,
   input  logic [7:0]             out_zp,
   input  logic [7:0]             act_min,
   input  logic [7:0]             act_max,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [N*OUT_W-1:0]     out_data,
   output logic [1:0]             out_row,
   output logic                   out_last,
   output logic                   busy
);

   localparam int PROD_W = ACC_W + 32;

   typedef enum logic [1:0] {IDLE, DRAIN, FLUSH} state_t;

   state_t                  state;
   logic [N*N*ACC_W-1:0]    snap_c;
   logic [N-1:0]            pend;
   logic signed [31:0]      snap_qmult;
   logic [4:0]              snap_qshift;
   logic [7:0]              snap_zp;
   logic [7:0]              snap_min;
   logic [7:0]              snap_max;

   // Pipeline registers
   logic                    s1_valid;
   logic [1:0]              s1_row;
   logic                    s1_last;
   logic signed [PROD_W-1:0] s1_prod [N];
   logic                    s2_valid;
   logic [1:0]              s2_row;
   logic                    s2_last;
   logic signed [31:0]      s2_rnd [N];

   // Combinational helpers
   logic                    adv;
   logic                    found;
   logic                    issue;
   logic [1:0]              issue_row;
   logic [N-1:0]            pend_next;
   logic signed [ACC_W-1:0] row_acc [N];
   logic [5:0]              tot_shift;
   logic signed [PROD_W-1:0] rnd_bias;
   logic signed [PROD_W-1:0] rnd_sum [N];
   logic signed [PROD_W-1:0] rnd_shr [N];
   logic signed [32:0]      zp_ext;
   logic signed [32:0]      lo_ext;
   logic signed [32:0]      hi_ext;
   logic signed [32:0]      sat_v [N];
   logic [N*OUT_W-1:0]      q_row;

   // The whole pipeline moves only when the output register is free or being taken
   assign adv   = !out_valid || out_ready;
   assign issue = (state == DRAIN) && adv && found;

   // Pick the lowest still-pending row and read its accumulators from the snapshot
   always_comb begin
      issue_row = '0;
      found     = 1'b0;
      for (int unsigned r = 0; r < N; r++) begin
         if (pend[r] && !found) begin
            found     = 1'b1;
            issue_row = 2'(r);
         end
      end
      pend_next = pend;
      if (found) pend_next[issue_row] = 1'b0;
      for (int unsigned c = 0; c < N; c++) begin
         row_acc[c] = snap_c[(32'(issue_row) * N + c) * ACC_W +: ACC_W];
      end
   end

   // Rounding right shift by 31+qshift, round half toward +inf
   always_comb begin
      tot_shift = 6'd31 + {1'b0, snap_qshift};
      rnd_bias  = {{(PROD_W-1){1'b0}}, 1'b1} << (tot_shift - 6'd1);
      for (int unsigned c = 0; c < N; c++) begin
         rnd_sum[c] = s1_prod[c] + rnd_bias;
         rnd_shr[c] = rnd_sum[c] >>> tot_shift;
      end
   end

   // Zero-point add then clamp: low bound first, high bound wins on inverted range
   always_comb begin
      zp_ext = {{25{snap_zp[7]}}, snap_zp};
      lo_ext = {{25{snap_min[7]}}, snap_min};
      hi_ext = {{25{snap_max[7]}}, snap_max};
      q_row  = '0;
      for (int unsigned c = 0; c < N; c++) begin
         sat_v[c] = {s2_rnd[c][31], s2_rnd[c]} + zp_ext;
         if (sat_v[c] < lo_ext) sat_v[c] = lo_ext;
         if (sat_v[c] > hi_ext) sat_v[c] = hi_ext;
         q_row[c*OUT_W +: OUT_W] = sat_v[c][OUT_W-1:0];
      end
   end

   // Control FSM: snapshot on capture, walk the row mask, wait for the final beat
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state         <= IDLE;
         capture_ready <= 1'b1;
         busy          <= 1'b0;
         snap_c        <= '0;
         pend          <= '0;
         snap_qmult    <= '0;
         snap_qshift   <= '0;
         snap_zp       <= '0;
         snap_min      <= '0;
         snap_max      <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (capture) begin
                  snap_c      <= c_in;
                  snap_qmult  <= qmult;
                  snap_qshift <= qshift;
                  snap_zp     <= out_zp;
                  snap_min    <= act_min;
                  snap_max    <= act_max;
                  pend        <= row_mask;
                  if (row_mask != '0) begin
                     state         <= DRAIN;
                     busy          <= 1'b1;
                     capture_ready <= 1'b0;
                  end
               end
            end
            DRAIN: begin
               if (issue) begin
                  pend <= pend_next;
                  if (pend_next == '0) state <= FLUSH;
               end
            end
            FLUSH: begin
               if (out_valid && out_ready && out_last) begin
                  state         <= IDLE;
                  busy          <= 1'b0;
                  capture_ready <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Three-stage datapath; every stage holds together under backpressure
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1_valid  <= 1'b0;
         s1_row    <= '0;
         s1_last   <= 1'b0;
         s2_valid  <= 1'b0;
         s2_row    <= '0;
         s2_last   <= 1'b0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_row   <= '0;
         out_last  <= 1'b0;
         for (int unsigned c = 0; c < N; c++) begin
            s1_prod[c] <= '0;
            s2_rnd[c]  <= '0;
         end
      end else if (adv) begin
         s1_valid <= issue;
         if (issue) begin
            s1_row  <= issue_row;
            s1_last <= (pend_next == '0);
            for (int unsigned c = 0; c < N; c++) begin
               s1_prod[c] <= row_acc[c] * snap_qmult;
            end
         end
         s2_valid <= s1_valid;
         if (s1_valid) begin
            s2_row  <= s1_row;
            s2_last <= s1_last;
            for (int unsigned c = 0; c < N; c++) begin
               s2_rnd[c] <= rnd_shr[c][31:0];
            end
         end
         out_valid <= s2_valid;
         out_last  <= s2_valid && s2_last;
         if (s2_valid) begin
            out_data <= q_row;
            out_row  <= s2_row;
         end
      end
   end

endmodule

// File: tb/tb_sta_output_requant.sv
// Directed bench for sta_output_requant with hand-computed expected beats.
module tb_sta_output_requant;

   logic         clk = 1'b0;
   logic         reset;
   logic         capture;
   logic         capture_ready;
   logic [511:0] c_in;
   logic [3:0]   row_mask;
   logic [31:0]  qmult;
   logic [4:0]   qshift;
   logic [7:0]   out_zp;
   logic [7:0]   act_min;
   logic [7:0]   act_max;
   logic         out_valid;
   logic         out_ready;
   logic [31:0]  out_data;
   logic [1:0]   out_row;
   logic         out_last;
   logic         busy;

   int total = 0;
   int bad   = 0;
   int acc [16];
   logic [31:0] exp_data [4];
   int          exp_row  [4];

   sta_output_requant #(.N(4), .ACC_W(32), .OUT_W(8)) dut (
      .clk(clk), .reset(reset), .capture(capture), .capture_ready(capture_ready),
      .c_in(c_in), .row_mask(row_mask), .qmult(qmult), .qshift(qshift),
      .out_zp(out_zp), .act_min(act_min), .act_max(act_max),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_row(out_row), .out_last(out_last), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_row(input int r, input int a0, input int a1, input int a2, input int a3);
      acc[r*4+0] = a0;
      acc[r*4+1] = a1;
      acc[r*4+2] = a2;
      acc[r*4+3] = a3;
   endtask

   task automatic load_cin();
      for (int i = 0; i < 16; i++) c_in[i*32 +: 32] = acc[i];
   endtask

   task automatic do_capture(input logic [3:0] m, input logic [31:0] qm, input logic [4:0] qs,
                             input logic [7:0] zp, input logic [7:0] amin, input logic [7:0] amax);
      load_cin();
      row_mask = m;
      qmult    = qm;
      qshift   = qs;
      out_zp   = zp;
      act_min  = amin;
      act_max  = amax;
      capture  = 1'b1;
      tick();
      capture  = 1'b0;
   endtask

   // Collect nexp beats; optionally stall stall_len cycles when beat stall_beat is presented
   task automatic run_tile(input int nexp, input int stall_beat, input int stall_len, input int first_lat);
      int beat;
      int stalls;
      beat   = 0;
      stalls = 0;
      out_ready = 1'b1;
      for (int cyc = 1; cyc <= 40 && beat < nexp; cyc++) begin
         tick();
         if (out_valid) begin
            if (beat == 0 && stalls == 0 && first_lat > 0) begin
               chk("first_lat", cyc, first_lat);
               chk("busy_drain", busy, 1);
            end
            if (beat == stall_beat && stalls < stall_len) begin
               out_ready = 1'b0;
               stalls++;
               chk("stall_row", out_row, exp_row[beat]);
               chk("stall_data", out_data, exp_data[beat]);
            end else begin
               out_ready = 1'b1;
               chk("row", out_row, exp_row[beat]);
               chk("data", out_data, exp_data[beat]);
               chk("last", out_last, beat == nexp - 1);
               beat++;
            end
         end
      end
      chk("beats", beat, nexp);
      out_ready = 1'b1;
      tick();
      chk("done_valid", out_valid, 0);
      chk("done_cap_rdy", capture_ready, 1);
      chk("done_busy", busy, 0);
   endtask

   task automatic tile1_setup();
      set_row(0, 100, 101, -3, 1000);
      set_row(1, 0, 1, 2, 3);
      set_row(2, -1, -2, -255, -1000);
      set_row(3, 254, 255, -256, 7);
      exp_row[0] = 0; exp_data[0] = 32'h7FFF3332;
      exp_row[1] = 1; exp_data[1] = 32'h02010100;
      exp_row[2] = 2; exp_data[2] = 32'h8081FF00;
      exp_row[3] = 3; exp_data[3] = 32'h04807F7F;
   endtask

   initial begin
      reset     = 1'b1;
      capture   = 1'b0;
      c_in      = '0;
      row_mask  = '0;
      qmult     = '0;
      qshift    = '0;
      out_zp    = '0;
      act_min   = '0;
      act_max   = '0;
      out_ready = 1'b1;
      for (int i = 0; i < 16; i++) acc[i] = 0;

      repeat (2) @(posedge clk);
      #1;
      chk("rst_cap_rdy", capture_ready, 1);
      chk("rst_valid", out_valid, 0);
      chk("rst_data", out_data, 0);
      chk("rst_row", out_row, 0);
      chk("rst_last", out_last, 0);
      chk("rst_busy", busy, 0);
      reset = 1'b0;
      tick();

      // Basic + full tile, Q31 multiplier of 0.5
      tile1_setup();
      do_capture(4'hF, 32'h4000_0000, 5'd0, 8'h00, 8'h80, 8'h7F);
      run_tile(4, -1, 0, 3);

      // Backpressure on beat 1 for 5 cycles
      do_capture(4'hF, 32'h4000_0000, 5'd0, 8'h00, 8'h80, 8'h7F);
      run_tile(4, 1, 5, 3);

      // Capture while busy with different data is ignored
      do_capture(4'hF, 32'h4000_0000, 5'd0, 8'h00, 8'h80, 8'h7F);
      for (int i = 0; i < 16; i++) acc[i] = 1000;
      load_cin();
      row_mask = 4'b0001;
      qmult    = 32'h7FFF_FFFF;
      out_zp   = 8'h10;
      capture  = 1'b1;
      tick();
      chk("busy_cap_rdy", capture_ready, 0);
      tick();
      capture = 1'b0;
      run_tile(4, -1, 0, 0);

      // Empty mask: nothing happens
      do_capture(4'b0000, 32'h4000_0000, 5'd0, 8'h00, 8'h80, 8'h7F);
      chk("empty_cap_rdy", capture_ready, 1);
      chk("empty_busy", busy, 0);
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("empty_valid", out_valid, 0);
      end

      // Sparse mask, zero point -128
      for (int i = 0; i < 16; i++) acc[i] = 0;
      exp_row[0] = 1; exp_data[0] = 32'h80808080;
      exp_row[1] = 3; exp_data[1] = 32'h80808080;
      do_capture(4'b1010, 32'h4000_0000, 5'd0, 8'h80, 8'h80, 8'h7F);
      run_tile(2, -1, 0, 3);

      // ReLU-style clamp [0,127]
      set_row(0, -50, 10, 300, -1);
      exp_row[0] = 0; exp_data[0] = 32'h007F0500;
      do_capture(4'b0001, 32'h4000_0000, 5'd0, 8'h00, 8'h00, 8'h7F);
      run_tile(1, -1, 0, 3);

      // Extra shift of 1 plus zero point 3
      set_row(0, 10, -6, 5, 6);
      exp_row[0] = 0; exp_data[0] = 32'h05040206;
      do_capture(4'b0001, 32'h4000_0000, 5'd1, 8'h03, 8'h80, 8'h7F);
      run_tile(1, -1, 0, 3);

      // Inverted clamp range resolves to act_max
      set_row(2, 0, 0, 0, 0);
      exp_row[0] = 2; exp_data[0] = 32'h0A0A0A0A;
      do_capture(4'b0100, 32'h4000_0000, 5'd0, 8'h00, 8'd20, 8'd10);
      run_tile(1, -1, 0, 3);

      // Asynchronous reset in the middle of a drain
      tile1_setup();
      do_capture(4'hF, 32'h4000_0000, 5'd0, 8'h00, 8'h80, 8'h7F);
      repeat (4) tick();
      chk("pre_rst_row", out_row, 1);
      #2 reset = 1'b1;
      #1;
      chk("arst_valid", out_valid, 0);
      chk("arst_cap_rdy", capture_ready, 1);
      chk("arst_busy", busy, 0);
      #1 reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("post_rst_valid", out_valid, 0);
      end
      do_capture(4'hF, 32'h4000_0000, 5'd0, 8'h00, 8'h80, 8'h7F);
      run_tile(4, -1, 0, 3);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
